// File: rtl/noc_tree_pkg.sv
// Shared types and field helpers for the binary-tree NoC router.
// Packet layout: {addr, dest, payload}, addr in the MSBs.
package noc_tree_pkg;

  localparam int WIDTH_packet = 14;
  localparam int WIDTH_addr   = 3;
  localparam int WIDTH_dest   = 3;

  typedef logic [WIDTH_packet-1:0] packet_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

  function automatic logic [WIDTH_addr-1:0] pkt_addr(input packet_t p);
    return p[WIDTH_packet-1 -: WIDTH_addr];
  endfunction

  function automatic logic [WIDTH_dest-1:0] pkt_dest(input packet_t p);
    return p[WIDTH_packet-WIDTH_addr-1 -: WIDTH_dest];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping.
// Zero latency; no state, the caller owns the pointer.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic found;
  int   idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    idx          = 0;
    any_req      = |req;
    // k = N revisits last_grant itself, so a lone repeat requester still wins
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_idx         = IW'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tree_out_port_arbiter.sv
// Output-port arbiter: round-robin grant among input controllers into a one-entry output register.
// Packet appears one cycle after req_ready; reloads in the same cycle it drains, so no bubbles.
module tree_out_port_arbiter
  import noc_tree_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int WIDTH_cnt = 16,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*WIDTH_packet-1:0] req_packet,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  output logic [WIDTH_packet-1:0]         out_packet,
  input  logic                            out_ready,
  output logic [IW-1:0]                   out_src,
  output logic [WIDTH_cnt-1:0]            pkt_count
);

  out_state_t           state_q, state_d;
  packet_t              pkt_q, pkt_d;
  logic [IW-1:0]        src_q, src_d;
  logic [IW-1:0]        last_grant_q, last_grant_d;
  logic [WIDTH_cnt-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   grant_onehot;
  logic [IW-1:0]        grant_idx;
  logic                 any_req;
  logic                 load, accept, drain;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req          (req_valid),
    .last_grant   (last_grant_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_req      (any_req)
  );

  assign load   = (state_q == EMPTY) || out_ready;
  assign accept = load && any_req && !rst;
  assign drain  = (state_q == FULL) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (any_req) state_d = FULL;
      FULL:    if (out_ready) state_d = any_req ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
    req_ready = accept ? grant_onehot : '0;
  end

  // Payload is only sampled on an accepted transfer, so idle requester buses never leak in
  always_comb begin
    pkt_d        = pkt_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q + WIDTH_cnt'(drain);
    if (accept) begin
      pkt_d        = req_packet[int'(grant_idx)*WIDTH_packet +: WIDTH_packet];
      src_d        = grant_idx;
      last_grant_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q        <= '0;
      src_q        <= '0;
      last_grant_q <= IW'(NUM_REQ-1);
      cnt_q        <= '0;
    end else begin
      pkt_q        <= pkt_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_packet = pkt_q;
  assign out_src    = src_q;
  assign pkt_count  = cnt_q;

endmodule

// File: tb/tb_tree_out_port_arbiter.sv
// Bench for tree_out_port_arbiter: directed scenarios with literal pins, then randomized traffic
// compared every cycle against a transaction-level model of the output stage.
module tb_tree_out_port_arbiter;
  import noc_tree_pkg::*;

  localparam int N  = 3;
  localparam int W  = WIDTH_packet;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_packet;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_packet;
  logic           out_ready;
  logic [1:0]     out_src;
  logic [CW-1:0]  pkt_count;

  always #5 clk = ~clk;

  tree_out_port_arbiter #(.NUM_REQ(N), .WIDTH_cnt(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_packet (req_packet),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_packet (out_packet),
    .out_ready  (out_ready),
    .out_src    (out_src),
    .pkt_count  (pkt_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: the single held packet, its source, the priority pointer and the delivered count
  bit      m_known = 1'b0;
  bit      m_vld   = 1'b0;
  packet_t m_pkt   = '0;
  int      m_src   = 0;
  int      m_last  = N-1;
  int      m_cnt   = 0;

  logic [N-1:0]  obs_rr;
  logic          obs_vld;
  logic [W-1:0]  obs_pkt;
  logic [1:0]    obs_src;
  logic [CW-1:0] obs_cnt;

  logic [N-1:0] cur_vld;
  packet_t      cur_pkt [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N*W-1:0] pack3(input packet_t a, input packet_t b, input packet_t c);
    return {c, b, a};
  endfunction

  // One clock cycle: drive, compare against the model, then advance the model on the edge
  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] p, input logic rdy);
    int         w;
    bit         can_load;
    logic [N-1:0] exp_rr;
    rst = r; req_valid = v; req_packet = p; out_ready = rdy;
    #1;
    w        = winner(v, m_last);
    can_load = !m_vld || rdy;
    exp_rr   = (!r && can_load && w >= 0) ? (N'(1) << w) : '0;
    obs_rr = req_ready; obs_vld = out_valid; obs_pkt = out_packet;
    obs_src = out_src; obs_cnt = pkt_count;
    check("req_ready", 32'(obs_rr), 32'(exp_rr));
    if (m_known) begin
      check("out_valid",  32'(obs_vld), 32'(m_vld));
      check("out_packet", 32'(obs_pkt), 32'(m_pkt));
      check("out_src",    32'(obs_src), 32'(m_src));
      check("pkt_count",  32'(obs_cnt), 32'(m_cnt));
    end
    @(posedge clk);
    if (r) begin
      m_vld = 1'b0; m_pkt = '0; m_src = 0; m_cnt = 0; m_last = N-1; m_known = 1'b1;
    end else begin
      if (m_vld && rdy) m_cnt = (m_cnt + 1) % (1 << CW);
      if (can_load) begin
        if (w >= 0) begin
          m_vld = 1'b1; m_pkt = p[w*W +: W]; m_src = w; m_last = w;
        end else begin
          m_vld = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int g;
    logic [N*W-1:0] pk;
    rst = 1'b1; req_valid = '0; req_packet = '0; out_ready = 1'b0;
    @(negedge clk);

    check("pkt_addr", 32'(pkt_addr(14'h1ABC)), 32'd3);
    check("pkt_dest", 32'(pkt_dest(14'h1ABC)), 32'd2);

    // Reset held with everyone requesting
    pk = pack3(14'h0011, 14'h0022, 14'h0033);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b111, pk, 1'b1);
      check("rst_req_ready", 32'(obs_rr), 32'd0);
    end
    step(1'b0, 3'b000, pk, 1'b1);
    check("rst_out_valid", 32'(obs_vld), 32'd0);
    check("rst_pkt_count", 32'(obs_cnt), 32'd0);

    // Single requester
    step(1'b0, 3'b010, pack3(14'h0, 14'h2A5, 14'h0), 1'b1);
    check("single_grant", 32'(obs_rr), 32'b010);
    step(1'b0, 3'b000, '0, 1'b1);
    check("single_valid", 32'(obs_vld), 32'd1);
    check("single_pkt",   32'(obs_pkt), 32'h2A5);
    check("single_src",   32'(obs_src), 32'd1);
    step(1'b0, 3'b000, '0, 1'b1);
    check("single_count", 32'(obs_cnt), 32'd1);

    // Fairness from fresh reset
    step(1'b1, 3'b000, '0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'b111, pack3(14'h100, 14'h200, 14'h300), 1'b1);
      check("rr_order", 32'(onehot_idx(obs_rr)), 32'(i % 3));
      if (i > 0) check("rr_no_bubble", 32'(obs_vld), 32'd1);
    end
    step(1'b0, 3'b000, '0, 1'b1);
    step(1'b0, 3'b000, '0, 1'b1);
    check("rr_count", 32'(obs_cnt), 32'd6);

    // Backpressure
    step(1'b1, 3'b000, '0, 1'b1);
    step(1'b0, 3'b001, pack3(14'h155, 14'h0, 14'h0), 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'b111, pack3(14'h0A0, 14'h0A1, 14'h0A2), 1'b0);
      check("bp_no_grant", 32'(obs_rr), 32'd0);
      check("bp_hold",     32'(obs_pkt), 32'h155);
    end
    step(1'b0, 3'b111, pack3(14'h0A0, 14'h0A1, 14'h0A2), 1'b1);
    check("bp_release_grant", 32'(obs_rr), 32'b010);
    step(1'b0, 3'b000, '0, 1'b0);
    check("bp_reload_pkt", 32'(obs_pkt), 32'h0A1);
    check("bp_reload_vld", 32'(obs_vld), 32'd1);

    // Wrap and skip
    step(1'b1, 3'b000, '0, 1'b1);
    step(1'b0, 3'b100, pack3(14'h0, 14'h0, 14'h3C1), 1'b1);
    check("wrap_first", 32'(obs_rr), 32'b100);
    step(1'b0, 3'b100, pack3(14'h0, 14'h0, 14'h3C2), 1'b1);
    check("wrap_again", 32'(obs_rr), 32'b100);
    step(1'b0, 3'b011, pack3(14'h011, 14'h012, 14'h0), 1'b1);
    check("wrap_skip", 32'(obs_rr), 32'b001);

    // Reset while holding a stalled packet
    step(1'b1, 3'b000, '0, 1'b1);
    step(1'b0, 3'b001, pack3(14'h3C3, 14'h0, 14'h0), 1'b1);
    step(1'b0, 3'b000, '0, 1'b0);
    step(1'b1, 3'b111, pack3(14'h001, 14'h002, 14'h003), 1'b0);
    check("midrst_no_grant", 32'(obs_rr), 32'd0);
    step(1'b0, 3'b111, pack3(14'h001, 14'h002, 14'h003), 1'b1);
    check("midrst_flushed", 32'(obs_vld), 32'd0);
    check("midrst_grant0",  32'(obs_rr), 32'b001);

    // Randomized traffic; stalled requesters keep their packet or withdraw
    cur_vld = '0;
    for (int i = 0; i < N; i++) cur_pkt[i] = '0;
    obs_rr = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (cur_vld[i] && !obs_rr[i]) begin
          if ($urandom_range(3) == 0) cur_vld[i] = 1'b0;
        end else begin
          cur_vld[i] = 1'($urandom_range(1));
          if (cur_vld[i]) cur_pkt[i] = packet_t'($urandom);
        end
      end
      g = $urandom_range(299);
      step(g == 0, cur_vld, pack3(cur_pkt[0], cur_pkt[1], cur_pkt[2]), $urandom_range(3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
